// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants and FSM encoding for the HUB75 capture block
package hub75_pkg;

    localparam int COLS_DEFAULT      = 64;
    localparam int HALF_ROWS_DEFAULT = 16;
    localparam int RGB_W             = 3;
    localparam int CNT_MAX           = 127;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } captureState_t;

    // A column clock is OE high with LAT low; OE and LAT together is a blanked latch, not a shift
    function automatic logic isShift(input logic oe, input logic lat);
        return oe && !lat;
    endfunction

endpackage

// File: rtl/hub75_row_shifter.sv
// rtl/hub75_row_shifter.sv - one half-panel column shift register with parallel output
module hub75_row_shifter
    import hub75_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shiftEn,
    input  logic [RGB_W-1:0]      pixel,
    output logic [COLS*RGB_W-1:0] rowData
);

    // Newest sample enters at column COLS-1, column 0 holds the oldest retained one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowData <= '0;
        end else if (shiftEn) begin
            rowData <= {pixel, rowData[COLS*RGB_W-1:RGB_W]};
        end
    end

endmodule

// File: rtl/hub75_capture.sv
// rtl/hub75_capture.sv - HUB75 panel receiver rebuilding the displayed frame for readback
module hub75_capture
    import hub75_pkg::*;
#(
    parameter int COLS      = COLS_DEFAULT,
    parameter int HALF_ROWS = HALF_ROWS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       R0,
    input  logic       G0,
    input  logic       B0,
    input  logic       R1,
    input  logic       G1,
    input  logic       B1,
    input  logic       OE,
    input  logic       LAT,
    input  logic [4:0] rd_row,
    input  logic [5:0] rd_col,
    output logic [2:0] rd_rgb,
    output logic       row_valid,
    output logic [3:0] row_addr,
    output logic       frame_done,
    output logic       short_row,
    output logic [6:0] shift_cnt
);

    localparam int         ROWS      = 2 * HALF_ROWS;
    localparam int         ROW_W     = COLS * RGB_W;
    localparam logic [3:0] LAST_ADDR = 4'(HALF_ROWS - 1);
    localparam logic [6:0] CNT_SAT   = 7'(CNT_MAX);
    localparam logic [6:0] FULL_ROW  = 7'(COLS);

    logic [3:0]       pinAddr;
    logic [2:0]       pinUpper;
    logic [2:0]       pinLower;
    logic             pinOe;
    logic             pinLat;
    logic             pinLatPrev;
    logic             shiftNow;
    logic             latchNow;
    logic [ROW_W-1:0] upperData;
    logic [ROW_W-1:0] lowerData;
    logic [7:0]       rdLsb;
    captureState_t    state;
    logic [ROW_W-1:0] frame [ROWS];

    // Input stage: every pin is registered once; the previous LAT is kept for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pinAddr    <= '0;
            pinUpper   <= '0;
            pinLower   <= '0;
            pinOe      <= 1'b0;
            pinLat     <= 1'b0;
            pinLatPrev <= 1'b0;
        end else begin
            pinAddr    <= {D, C, B, A};
            pinUpper   <= {R0, G0, B0};
            pinLower   <= {R1, G1, B1};
            pinOe      <= OE;
            pinLat     <= LAT;
            pinLatPrev <= pinLat;
        end
    end

    assign shiftNow = isShift(pinOe, pinLat);
    assign latchNow = pinLat && !pinLatPrev;
    assign rdLsb    = {2'b00, rd_col} + {1'b0, rd_col, 1'b0};

    hub75_row_shifter #(.COLS(COLS)) upperShifter (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (shiftNow),
        .pixel   (pinUpper),
        .rowData (upperData)
    );

    hub75_row_shifter #(.COLS(COLS)) lowerShifter (
        .clk     (clk),
        .rst     (rst),
        .shiftEn (shiftNow),
        .pixel   (pinLower),
        .rowData (lowerData)
    );

    // Row capture FSM with its registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row_valid  <= 1'b0;
            row_addr   <= '0;
            frame_done <= 1'b0;
            short_row  <= 1'b0;
            shift_cnt  <= '0;
        end else begin
            row_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (state == S_COMMIT) begin
                shift_cnt <= '0;
            end else if (shiftNow && shift_cnt != CNT_SAT) begin
                shift_cnt <= shift_cnt + 7'd1;
            end

            case (state)
                S_IDLE: begin
                    if (latchNow) begin
                        state <= S_COMMIT;
                    end else if (shiftNow) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (latchNow) begin
                        state <= S_COMMIT;
                    end else if (!pinOe && !pinLat) begin
                        state <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    if (shift_cnt < FULL_ROW) begin
                        short_row <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The latched address doubles as the commit write address during S_COMMIT
            if (latchNow && state != S_COMMIT) begin
                row_valid  <= 1'b1;
                row_addr   <= pinAddr;
                frame_done <= (pinAddr == LAST_ADDR);
            end
        end
    end

    // Frame store: commit writes both halves; the read port samples the pre-write contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                frame[r] <= '0;
            end
            rd_rgb <= '0;
        end else begin
            rd_rgb <= frame[rd_row][rdLsb +: RGB_W];
            if (state == S_COMMIT) begin
                frame[{1'b0, row_addr}] <= upperData;
                frame[{1'b1, row_addr}] <= lowerData;
            end
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
// tb/tb_hub75_capture.sv - randomized model-checked bench for hub75_capture
module tb_hub75_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT;
    logic [4:0] rd_row;
    logic [5:0] rd_col;
    logic [2:0] rd_rgb;
    logic       row_valid;
    logic [3:0] row_addr;
    logic       frame_done;
    logic       short_row;
    logic [6:0] shift_cnt;

    always #5 clk = ~clk;

    hub75_capture dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .OE(OE), .LAT(LAT),
        .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
        .row_valid(row_valid), .row_addr(row_addr), .frame_done(frame_done),
        .short_row(short_row), .shift_cnt(shift_cnt)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [2:0] up;
        logic [2:0] lo;
        logic       oe;
        logic       lat;
    } pinT;

    int checks = 0;
    int errors = 0;

    // Panel model: last 64 samples per half, a 32x64 displayed image, and status bookkeeping
    logic [2:0] mFrame [32][64];
    logic [2:0] qU[$];
    logic [2:0] qL[$];
    logic [2:0] pendU [64];
    logic [2:0] pendL [64];
    int         mCnt;
    bit         mShort, mPrevLat, mPending, eValid, eDone;
    logic [3:0] mAddr;
    logic [2:0] eRgb;
    pinT        held;
    bit         randRd = 1'b1;
    int         rvSeen, fdSeen;

    function automatic pinT mkPin(input logic [3:0] a, input logic [2:0] u, input logic [2:0] l,
                                  input logic oe, input logic lat);
        pinT p;
        p.addr = a; p.up = u; p.lo = l; p.oe = oe; p.lat = lat;
        return p;
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) mFrame[r][c] = 3'd0;
        qU.delete(); qL.delete();
        for (int c = 0; c < 64; c++) begin qU.push_back(3'd0); qL.push_back(3'd0); end
        mCnt = 0; mShort = 0; mPrevLat = 0; mPending = 0; mAddr = 0;
        eRgb = 0; eValid = 0; eDone = 0; held = '0;
    endfunction

    // Advance the panel by one clock, given the pins the input stage holds
    function automatic void modelStep(input pinT p);
        eRgb = mFrame[rd_row][rd_col];
        eValid = 0; eDone = 0;
        if (mPending) begin
            for (int c = 0; c < 64; c++) begin
                mFrame[{1'b0, mAddr}][c] = pendU[c];
                mFrame[{1'b1, mAddr}][c] = pendL[c];
            end
            if (mCnt < 64) mShort = 1;
            mCnt = 0;
            mPending = 0;
        end
        if (p.oe && !p.lat) begin
            qU.push_back(p.up); qL.push_back(p.lo);
            void'(qU.pop_front()); void'(qL.pop_front());
            if (mCnt < 127) mCnt++;
        end
        if (p.lat && !mPrevLat) begin
            eValid = 1; mAddr = p.addr; eDone = (p.addr == 4'd15);
            for (int c = 0; c < 64; c++) begin pendU[c] = qU[c]; pendL[c] = qL[c]; end
            mPending = 1;
        end
        mPrevLat = p.lat;
    endfunction

    task automatic checkLit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input pinT p);
        if (randRd) begin rd_row = 5'($urandom); rd_col = 6'($urandom); end
        {D, C, B, A} = p.addr; {R0, G0, B0} = p.up; {R1, G1, B1} = p.lo; OE = p.oe; LAT = p.lat;
        @(posedge clk);
        if (rst) modelReset();
        else begin modelStep(held); held = p; end
        #1;
        if (row_valid === 1'b1) rvSeen++;
        if (frame_done === 1'b1) fdSeen++;
        checks++;
        if ({rd_rgb, row_valid, row_addr, frame_done, short_row, shift_cnt} !==
            {eRgb, eValid, mAddr, eDone, mShort, 7'(mCnt)}) begin
            errors++;
            $display("FAIL cycle t=%0t got rgb=%0d rv=%0d addr=%0d fd=%0d sr=%0d cnt=%0d expected rgb=%0d rv=%0d addr=%0d fd=%0d sr=%0d cnt=%0d",
                     $time, rd_rgb, row_valid, row_addr, frame_done, short_row, shift_cnt,
                     eRgb, eValid, mAddr, eDone, mShort, mCnt);
        end
    endtask

    task automatic readLit(input logic [4:0] r, input logic [5:0] c, input logic [2:0] exp, input string name);
        randRd = 0; rd_row = r; rd_col = c;
        cycle('0);
        randRd = 1;
        checkLit(name, int'(rd_rgb), int'(exp));
    endtask

    // mode 0: constant cu/cl, 1: shift index mod 8, 2: random data with blank gaps and random OE on LAT
    task automatic sendRow(input logic [3:0] addr, input int n, input int latLen, input int mode,
                           input logic [2:0] cu, input logic [2:0] cl);
        pinT p;
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && $urandom_range(7) == 0) cycle(mkPin(addr, 3'($urandom), 3'($urandom), 1'b0, 1'b0));
            case (mode)
                0: p = mkPin(addr, cu, cl, 1'b1, 1'b0);
                1: p = mkPin(addr, 3'(i % 8), 3'(i % 8), 1'b1, 1'b0);
                default: p = mkPin(addr, 3'($urandom), 3'($urandom), 1'b1, 1'b0);
            endcase
            cycle(p);
        end
        for (int i = 0; i < latLen; i++)
            cycle(mkPin(addr, 3'($urandom), 3'($urandom), (mode == 2) ? 1'($urandom) : 1'b1, 1'b1));
        cycle(mkPin(addr, 3'd0, 3'd0, 1'b0, 1'b0));
        cycle('0);
        cycle('0);
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        #1;
        checkLit("reset_async_outs", int'({rd_rgb, row_valid, row_addr, frame_done, short_row, shift_cnt}), 0);
        for (int i = 0; i < n; i++) cycle('0);
        rst = 1'b0;
    endtask

    initial begin
        {A, B, C, D, R0, G0, B0, R1, G1, B1, OE, LAT} = '0;
        rd_row = 0; rd_col = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkLit("reset_outs", int'({rd_rgb, row_valid, row_addr, frame_done, short_row, shift_cnt}), 0);
        rst = 1'b0;

        // One full row: constant colours at half-row 5
        rvSeen = 0;
        sendRow(4'd5, 64, 1, 0, 3'b100, 3'b011);
        checkLit("t1_row_valid_count", rvSeen, 1);
        checkLit("t1_row_addr", int'(row_addr), 5);
        checkLit("t1_short_row", int'(short_row), 0);
        checkLit("t1_shift_cnt_cleared", int'(shift_cnt), 0);
        for (int c = 0; c < 64; c++) begin
            readLit(5'd5, 6'(c), 3'b100, "t1_upper");
            readLit(5'd21, 6'(c), 3'b011, "t1_lower");
        end

        // 65 shifts: the first sample falls off the far end
        sendRow(4'd2, 65, 1, 1, 3'd0, 3'd0);
        readLit(5'd2, 6'd0, 3'd1, "t2_col0");
        readLit(5'd2, 6'd63, 3'd0, "t2_col63");
        readLit(5'd2, 6'd62, 3'd7, "t2_col62");
        readLit(5'd18, 6'd1, 3'd2, "t2_lower_col1");
        checkLit("t2_short_row", int'(short_row), 0);

        // Short row from a clean shift register
        doReset(2);
        sendRow(4'd9, 10, 1, 0, 3'b111, 3'b110);
        checkLit("t3_short_row", int'(short_row), 1);
        readLit(5'd9, 6'd53, 3'd0, "t3_col53");
        readLit(5'd9, 6'd54, 3'd7, "t3_col54");
        readLit(5'd25, 6'd63, 3'd6, "t3_lower_col63");

        // LAT held for 5 cycles with OE high: one commit, no counting while latched
        rvSeen = 0;
        for (int i = 0; i < 20; i++) cycle(mkPin(4'd3, 3'd2, 3'd1, 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) begin
            cycle(mkPin(4'd3, 3'd2, 3'd1, 1'b1, 1'b1));
            checkLit("t5_cnt_hold", int'(shift_cnt), (i < 2) ? 20 : 0);
        end
        cycle('0);
        cycle('0);
        checkLit("t5_row_valid_count", rvSeen, 1);
        checkLit("t3_short_sticky", int'(short_row), 1);

        // Full 16-row sweep with random pixels, then read back the whole frame
        fdSeen = 0;
        for (int a = 0; a < 16; a++)
            sendRow(4'(a), ($urandom_range(3) == 0) ? int'($urandom_range(70, 60)) : 64,
                    int'($urandom_range(3, 1)), 2, 3'd0, 3'd0);
        checkLit("t4_frame_done_count", fdSeen, 1);
        randRd = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++) begin
                rd_row = 5'(r); rd_col = 6'(c);
                cycle('0);
            end
        randRd = 1;

        // Assorted random rows of arbitrary length
        for (int k = 0; k < 20; k++)
            sendRow(4'($urandom), int'($urandom_range(80)), int'($urandom_range(4, 1)), 2, 3'd0, 3'd0);

        // Reset part-way through a row, then one clean row at half-row 0
        for (int i = 0; i < 30; i++) cycle(mkPin(4'd7, 3'($urandom), 3'($urandom), 1'b1, 1'b0));
        doReset(3);
        sendRow(4'd0, 64, 1, 0, 3'b101, 3'b010);
        checkLit("t6_short_row", int'(short_row), 0);
        readLit(5'd0, 6'd10, 3'b101, "t6_upper");
        readLit(5'd16, 6'd10, 3'b010, "t6_lower");
        readLit(5'd5, 6'd0, 3'd0, "t6_old_row_cleared");
        readLit(5'd9, 6'd54, 3'd0, "t6_old_row9_cleared");
        for (int i = 0; i < 50; i++) cycle('0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
